// File: rtl/uart_pkg.sv
// Shared UART constants and the receive-FSM state type.
// The host transmit path imports the same package.
package uart_pkg;

  localparam int UART_BYTES_PER_PKT = 4;
  localparam int UART_CLKS_PER_BIT  = 434;
  localparam int UART_TIMEOUT_CLKS  = 50000;
  localparam int UART_DATA_BITS     = 8;
  localparam int UART_LANE_W        = $clog2(UART_BYTES_PER_PKT);
  localparam int UART_HOLD_W        = UART_DATA_BITS * (UART_BYTES_PER_PKT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// RX synchronizer plus 8N1 byte receiver.
// The bit timer is a down-counter; each sample point is where it reaches zero.
//   state | meaning
//   IDLE  | line high, waiting for a falling edge
//   START | half-bit wait, then confirm the start bit is still low
//   DATA  | one sample per bit period, LSB first
//   STOP  | sample the stop bit
//   BREAK | bad stop bit seen, waiting for the line to return high
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] rx_byte,
  output logic                      byte_rdy,
  output logic                      frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] LAST_BIT    = IDX_W'(UART_DATA_BITS - 1);

  logic                      r_rx_meta;
  logic                      r_rx_sync;
  logic                      r_rx_prev;
  uart_rx_state_t            r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic [IDX_W-1:0]          r_bit_idx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic                      r_byte_rdy;
  logic                      r_frame_err;

  uart_rx_state_t            w_state_nxt;
  logic [CNT_W-1:0]          w_cnt_nxt;
  logic [IDX_W-1:0]          w_bit_idx_nxt;
  logic [UART_DATA_BITS-1:0] w_shift_nxt;
  logic                      w_byte_done;
  logic                      w_frame_bad;
  logic                      w_tick;

  assign w_tick = (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_byte_rdy  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_byte_rdy  <= w_byte_done;
      r_frame_err <= w_frame_bad;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_byte_done   = 1'b0;
    w_frame_bad   = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_rx_prev && !r_rx_sync) begin
          w_state_nxt = START;
          w_cnt_nxt   = HALF_RELOAD;
        end
      end
      START: begin
        if (w_tick) begin
          // a start bit that is already high again was a glitch
          if (!r_rx_sync) begin
            w_state_nxt   = DATA;
            w_cnt_nxt     = BIT_RELOAD;
            w_bit_idx_nxt = '0;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      DATA: begin
        if (w_tick) begin
          w_shift_nxt = {r_rx_sync, r_shift[UART_DATA_BITS-1:1]};
          w_cnt_nxt   = BIT_RELOAD;
          if (r_bit_idx == LAST_BIT) begin
            w_state_nxt = STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      STOP: begin
        if (w_tick) begin
          if (r_rx_sync) begin
            w_byte_done = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_frame_bad = 1'b1;
            w_state_nxt = BREAK;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      BREAK: begin
        if (r_rx_sync) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign rx_byte   = r_shift;
  assign byte_rdy  = r_byte_rdy;
  assign frame_err = r_frame_err;

endmodule

// File: rtl/uart_pkt_rx.sv
// Host UART receive path: bytes from uart_rx_byte are packed four at a time,
// first byte in the low lane, with a timeout that drops stale partial packets.
module uart_pkt_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int TIMEOUT_CLKS = UART_TIMEOUT_CLKS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic [31:0] pkt_data,
  output logic        pkt_rdy,
  output logic        frame_err
);

  localparam int TMR_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TMR_W-1:0]       TMR_RELOAD = TMR_W'(TIMEOUT_CLKS);
  localparam logic [UART_LANE_W-1:0] LAST_LANE  = UART_LANE_W'(UART_BYTES_PER_PKT - 1);

  logic [UART_DATA_BITS-1:0] w_rx_byte;
  logic                      w_byte_rdy;
  logic                      w_frame_err;
  logic                      w_timeout;

  logic [UART_LANE_W-1:0]    r_count;
  logic [UART_HOLD_W-1:0]    r_hold;
  logic [TMR_W-1:0]          r_timer;
  logic [31:0]               r_pkt_data;
  logic                      r_pkt_rdy;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx_byte (
    .clk       (clk),
    .rst       (rst),
    .rx        (RX),
    .rx_byte   (w_rx_byte),
    .byte_rdy  (w_byte_rdy),
    .frame_err (w_frame_err)
  );

  // timer is reloaded by every byte and only counts while a packet is partial
  assign w_timeout = (r_count != '0) && (r_timer == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= '0;
      r_hold     <= '0;
      r_timer    <= '0;
      r_pkt_data <= '0;
      r_pkt_rdy  <= 1'b0;
    end else begin
      r_pkt_rdy <= 1'b0;
      if (w_byte_rdy) begin
        // a byte arriving on the expiry cycle still belongs to this packet
        r_timer <= TMR_RELOAD;
        if (r_count == LAST_LANE) begin
          r_pkt_data <= {w_rx_byte, r_hold};
          r_pkt_rdy  <= 1'b1;
          r_count    <= '0;
        end else begin
          r_hold[{r_count, 3'b000} +: UART_DATA_BITS] <= w_rx_byte;
          r_count <= r_count + 1'b1;
        end
      end else if (w_frame_err || w_timeout) begin
        r_count <= '0;
        r_hold  <= '0;
      end else if (r_count != '0) begin
        r_timer <= r_timer - 1'b1;
      end
    end
  end

  assign pkt_data  = r_pkt_data;
  assign pkt_rdy   = r_pkt_rdy;
  assign frame_err = w_frame_err;

endmodule

// File: tb/tb_uart_pkt_rx.sv
// Directed bench for uart_pkt_rx at 16 clocks per bit and a 400-cycle timeout.
module tb_uart_pkt_rx;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        RX;
  logic [31:0] pkt_data;
  logic        pkt_rdy;
  logic        frame_err;

  int n_checks = 0;
  int n_errors = 0;
  int n_pkt    = 0;
  int n_ferr   = 0;
  int n_double = 0;
  int n_change = 0;
  logic [31:0] last_pkt = 32'h0;
  logic        prev_rdy = 1'b0;

  always #5 clk = ~clk;

  uart_pkt_rx #(
    .CLKS_PER_BIT (CPB),
    .TIMEOUT_CLKS (400)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .RX        (RX),
    .pkt_data  (pkt_data),
    .pkt_rdy   (pkt_rdy),
    .frame_err (frame_err)
  );

  // Output monitor: pulse counts, held-value and pulse-width tracking.
  always @(negedge clk) begin
    if (rst) begin
      last_pkt = 32'h0;
      prev_rdy = 1'b0;
    end else begin
      if (pkt_rdy === 1'b1) begin
        n_pkt++;
        last_pkt = pkt_data;
        if (prev_rdy) n_double++;
      end else if (pkt_data !== last_pkt) begin
        n_change++;
      end
      if (frame_err === 1'b1) n_ferr++;
      prev_rdy = (pkt_rdy === 1'b1);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_val);
    RX = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (CPB) @(negedge clk);
    end
    RX = stop_val;
    repeat (CPB) @(negedge clk);
    RX = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[i*8 +: 8], 1'b1);
    end
  endtask

  task automatic idle(input int n);
    RX = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    RX  = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_pkt_data", pkt_data, 32'h0);
    check("reset_pkt_rdy", {31'h0, pkt_rdy}, 32'h0);
    check("reset_frame_err", {31'h0, frame_err}, 32'h0);
    rst = 1'b0;
    idle(10);

    // normal packet
    send_word(32'h44332211);
    idle(20);
    check("normal_count", n_pkt, 1);
    check("normal_data", pkt_data, 32'h44332211);
    check("normal_latched", last_pkt, 32'h44332211);
    check("normal_no_ferr", n_ferr, 0);

    // back-to-back packets, no gap
    send_word(32'hDEADBEEF);
    check("b2b_first_count", n_pkt, 2);
    check("b2b_first_data", pkt_data, 32'hDEADBEEF);
    send_word(32'h01020304);
    idle(20);
    check("b2b_second_count", n_pkt, 3);
    check("b2b_second_data", pkt_data, 32'h01020304);

    // timeout discards 0xAA, 0xBB
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    idle(500);
    check("timeout_no_pulse", n_pkt, 3);
    check("timeout_data_held", pkt_data, 32'h01020304);
    send_word(32'h04030201);
    idle(20);
    check("timeout_count", n_pkt, 4);
    check("timeout_data", pkt_data, 32'h04030201);

    // framing error on the second byte
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b0);
    idle(32);
    check("ferr_count", n_ferr, 1);
    check("ferr_data_held", pkt_data, 32'h04030201);
    check("ferr_no_pulse", n_pkt, 4);
    send_word(32'h13121110);
    idle(20);
    check("ferr_recover_count", n_pkt, 5);
    check("ferr_recover_data", pkt_data, 32'h13121110);

    // 3-cycle glitch on an idle line
    RX = 1'b0;
    repeat (3) @(negedge clk);
    idle(40);
    check("glitch_no_ferr", n_ferr, 1);
    send_word(32'hD4C3B2A1);
    idle(20);
    check("glitch_count", n_pkt, 6);
    check("glitch_data", pkt_data, 32'hD4C3B2A1);

    // reset after two bytes
    send_byte(8'h77, 1'b1);
    send_byte(8'h88, 1'b1);
    idle(5);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_pkt_data", pkt_data, 32'h0);
    check("midrst_pkt_rdy", {31'h0, pkt_rdy}, 32'h0);
    check("midrst_frame_err", {31'h0, frame_err}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(10);
    send_word(32'hCAFEF00D);
    idle(20);
    check("midrst_count", n_pkt, 7);
    check("midrst_data", pkt_data, 32'hCAFEF00D);

    check("no_double_pulse", n_double, 0);
    check("data_held_between", n_change, 0);
    check("total_ferr", n_ferr, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
